// File: rtl/rx_seq_extract_pkg.sv
// rx_seq_extract_pkg: parser states, framing bytes and header offsets shared by the extractor
package rx_seq_extract_pkg;
  typedef enum logic [1:0] {IDLE, PRE, HDR, DROP} state_t;
  localparam logic [7:0] PRE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE = 8'hD5;
  localparam logic [10:0] ETH_OFF = 11'd12;
  localparam logic [10:0] SEQ_OFF = 11'd14;
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return v + {15'd0, v != 16'hFFFF};
  endfunction
endpackage

// File: rtl/rx_seq_extract_pulse_stretch.sv
// pulse_stretch: holds pulse high for exactly W cycles after each load, reloading on repeat loads
module pulse_stretch #(
  parameter int W = 4
) (
  input  logic sysclk,
  input  logic nrst,
  input  logic load,
  output logic pulse
);
  localparam int CW = $clog2(W + 1);
  logic [CW-1:0] cnt;
  always_ff @(posedge sysclk) begin
    if (!nrst) begin
      cnt <= '0;
      pulse <= 1'b0;
    end else if (load) begin
      cnt <= CW'(W);
      pulse <= 1'b1;
    end else begin
      cnt <= cnt - CW'(cnt != '0);
      pulse <= cnt > CW'(1);
    end
  end
endmodule

// File: rtl/rx_seq_extract.sv
// rx_seq_extract: parses test frames, captures their sequence number and keeps accept/reject statistics
module rx_seq_extract
  import rx_seq_extract_pkg::*;
#(
  parameter logic [15:0] ETH_TYPE = 16'h88B5,
  parameter int MIN_LEN = 60,
  parameter int CPCL_W = 4
) (
  input  logic        sysclk,
  input  logic        nrst,
  input  logic        rx_dv,
  input  logic        rx_er,
  input  logic [7:0]  rx_data,
  input  logic        clr_cnt,
  output logic        cpcl,
  output logic [15:0] pkt_cnt,
  output logic [15:0] good_cnt,
  output logic [15:0] bad_cnt
);
  state_t state;
  logic [10:0] idx;
  logic [15:0] seq;
  logic err, eth_bad, dec, acc;
  always_comb begin
    dec = state == HDR && !rx_dv;
    acc = dec && !err && idx >= 11'(MIN_LEN) && idx >= SEQ_OFF + 11'd2;
  end
  always_ff @(posedge sysclk) begin
    if (!nrst) begin
      state <= IDLE;
      idx <= '0;
      err <= 1'b0;
      eth_bad <= 1'b0;
      seq <= '0;
      pkt_cnt <= '0;
      good_cnt <= '0;
      bad_cnt <= '0;
    end else begin
      if (acc) pkt_cnt <= seq;
      good_cnt <= clr_cnt ? '0 : good_cnt + {15'd0, acc};
      bad_cnt <= clr_cnt ? '0 : (dec && !acc) ? sat_inc16(bad_cnt) : bad_cnt;
      if ((state == PRE || state == HDR) && rx_dv && rx_er) err <= 1'b1;
      case (state)
        IDLE: begin
          err <= 1'b0;
          if (rx_dv) state <= rx_data == PRE_BYTE ? PRE : DROP;
        end
        PRE: begin
          idx <= '0;
          if (!rx_dv) state <= IDLE;
          else if (rx_data == SFD_BYTE) state <= HDR;
          else if (rx_data != PRE_BYTE) state <= DROP;
        end
        HDR: begin
          if (!rx_dv) state <= IDLE;
          else begin
            idx <= idx + {10'd0, idx != 11'h7FF};
            // high EtherType byte is remembered so the verdict lands on byte 13
            if (idx == ETH_OFF) eth_bad <= rx_data != ETH_TYPE[15:8];
            if (idx == ETH_OFF + 11'd1 && (eth_bad || rx_data != ETH_TYPE[7:0])) state <= DROP;
            if (idx == SEQ_OFF) seq[15:8] <= rx_data;
            if (idx == SEQ_OFF + 11'd1) seq[7:0] <= rx_data;
          end
        end
        default: if (!rx_dv) state <= IDLE;
      endcase
    end
  end
  pulse_stretch #(.W(CPCL_W)) u_stretch (
    .sysclk(sysclk),
    .nrst(nrst),
    .load(acc),
    .pulse(cpcl)
  );
endmodule

// File: tb/tb_rx_seq_extract.sv
// tb_rx_seq_extract: directed and random frames checked against a frame-level reference model
module tb_rx_seq_extract;
  localparam logic [15:0] ETH = 16'h88B5;
  localparam int MIN_LEN = 60;
  localparam int CPCL_W = 4;
  logic sysclk = 1'b0;
  logic nrst, rx_dv, rx_er, clr_cnt;
  logic [7:0] rx_data;
  logic cpcl;
  logic [15:0] pkt_cnt, good_cnt, bad_cnt;
  logic [15:0] m_pkt, m_good, m_bad;
  logic [7:0] frm[$];
  int er_pos;
  int n_chk = 0;
  int n_err = 0;
  rx_seq_extract #(.ETH_TYPE(ETH), .MIN_LEN(MIN_LEN), .CPCL_W(CPCL_W)) dut (
    .sysclk(sysclk),
    .nrst(nrst),
    .rx_dv(rx_dv),
    .rx_er(rx_er),
    .rx_data(rx_data),
    .clr_cnt(clr_cnt),
    .cpcl(cpcl),
    .pkt_cnt(pkt_cnt),
    .good_cnt(good_cnt),
    .bad_cnt(bad_cnt)
  );
  always #5 sysclk = ~sysclk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask
  task automatic drive(input logic [7:0] b, input logic er);
    rx_dv = 1'b1;
    rx_data = b;
    rx_er = er;
    tick();
  endtask
  task automatic build(input int pre_n, input int len, input logic [15:0] eth, input logic [15:0] s);
    frm = {};
    repeat (pre_n) frm.push_back(8'h55);
    frm.push_back(8'hD5);
    for (int k = 0; k < len; k++)
      frm.push_back(k == 12 ? eth[15:8] : k == 13 ? eth[7:0] : k == 14 ? s[15:8] : k == 15 ? s[7:0] : 8'($urandom));
    er_pos = -1;
  endtask
  // 0: silently dropped, 1: accepted, 2: rejected test frame
  function automatic int classify(output logic [15:0] s);
    int i, n;
    bit err;
    s = 16'h0;
    if (frm.size() == 0 || frm[0] != 8'h55) return 0;
    i = 0;
    while (i < frm.size() && frm[i] == 8'h55) i++;
    if (i == frm.size() || frm[i] != 8'hD5) return 0;
    n = frm.size() - i - 1;
    if (n >= 14 && {frm[i+13], frm[i+14]} != ETH) return 0;
    err = er_pos >= 1 && er_pos < frm.size();
    if (n < MIN_LEN || n < 16 || err) return 2;
    s = {frm[i+15], frm[i+16]};
    return 1;
  endfunction
  task automatic send_frame(input int gap, input bit clr);
    int res, hi;
    logic [15:0] s;
    res = classify(s);
    for (int i = 0; i < frm.size(); i++) drive(frm[i], i == er_pos);
    rx_dv = 1'b0;
    rx_er = 1'b0;
    rx_data = 8'h00;
    clr_cnt = clr;
    tick();
    clr_cnt = 1'b0;
    if (res == 1) begin
      m_pkt = s;
      m_good = m_good + 16'd1;
    end else if (res == 2 && m_bad != 16'hFFFF) m_bad = m_bad + 16'd1;
    if (clr) begin
      m_good = 16'd0;
      m_bad = 16'd0;
    end
    check("cpcl_rise", {31'd0, cpcl}, {31'd0, res == 1});
    check("pkt_cnt", {16'd0, pkt_cnt}, {16'd0, m_pkt});
    check("good_cnt", {16'd0, good_cnt}, {16'd0, m_good});
    check("bad_cnt", {16'd0, bad_cnt}, {16'd0, m_bad});
    hi = int'(cpcl);
    for (int k = 1; k < gap; k++) begin
      tick();
      hi += int'(cpcl);
    end
    check("cpcl_len", hi, res == 1 ? CPCL_W : 0);
  endtask
  initial begin
    int pre_n, len;
    logic [15:0] eth;
    nrst = 1'b0;
    rx_dv = 1'b0;
    rx_er = 1'b0;
    rx_data = 8'h00;
    clr_cnt = 1'b0;
    m_pkt = 16'd0;
    m_good = 16'd0;
    m_bad = 16'd0;
    repeat (3) tick();
    check("rst_cpcl", {31'd0, cpcl}, 32'd0);
    check("rst_pkt", {16'd0, pkt_cnt}, 32'd0);
    check("rst_good", {16'd0, good_cnt}, 32'd0);
    check("rst_bad", {16'd0, bad_cnt}, 32'd0);
    nrst = 1'b1;
    tick();
    build(7, 60, ETH, 16'h1234);
    send_frame(12, 1'b0);
    build(7, 60, ETH, 16'hABCD);
    er_pos = 8 + 30;
    send_frame(12, 1'b0);
    build(7, 40, ETH, 16'h0101);
    send_frame(12, 1'b0);
    build(7, 60, 16'h0800, 16'h0202);
    send_frame(12, 1'b0);
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    m_good = 16'd0;
    m_bad = 16'd0;
    check("clr_good", {16'd0, good_cnt}, 32'd0);
    check("clr_bad", {16'd0, bad_cnt}, 32'd0);
    build(7, 60, ETH, 16'hFFFF);
    send_frame(12, 1'b0);
    build(7, 60, ETH, 16'h0000);
    send_frame(12, 1'b0);
    build(7, 60, ETH, 16'h7E57);
    send_frame(12, 1'b1);
    build(7, 60, ETH, 16'h5A5A);
    for (int i = 0; i < 20; i++) drive(frm[i], 1'b0);
    nrst = 1'b0;
    for (int i = 20; i < 23; i++) drive(frm[i], 1'b0);
    check("mid_rst_cpcl", {31'd0, cpcl}, 32'd0);
    check("mid_rst_pkt", {16'd0, pkt_cnt}, 32'd0);
    check("mid_rst_good", {16'd0, good_cnt}, 32'd0);
    check("mid_rst_bad", {16'd0, bad_cnt}, 32'd0);
    nrst = 1'b1;
    m_pkt = 16'd0;
    m_good = 16'd0;
    m_bad = 16'd0;
    for (int i = 23; i < frm.size(); i++) drive(frm[i], 1'b0);
    rx_dv = 1'b0;
    len = 0;
    repeat (10) begin
      tick();
      len += int'(cpcl);
    end
    check("tail_cpcl", len, 0);
    check("tail_good", {16'd0, good_cnt}, 32'd0);
    check("tail_bad", {16'd0, bad_cnt}, 32'd0);
    build(7, 60, ETH, 16'h4242);
    send_frame(12, 1'b0);
    for (int f = 0; f < 40; f++) begin
      pre_n = $urandom_range(1, 7);
      len = ($urandom_range(0, 2) == 0) ? $urandom_range(5, 20) : $urandom_range(55, 80);
      eth = ($urandom_range(0, 4) == 0) ? 16'($urandom) : ETH;
      build(pre_n, len, eth, 16'($urandom));
      if ($urandom_range(0, 9) == 0) frm[$urandom_range(0, pre_n)] = 8'($urandom);
      if ($urandom_range(0, 4) == 0) er_pos = $urandom_range(0, frm.size() - 1);
      send_frame($urandom_range(6, 14), $urandom_range(0, 9) == 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/rx_seq_extract.md
RX_SEQ_EXTRACT -- requirements
Module: rx_seq_extract

Interface
REQ-001 Parameter ETH_TYPE, 16'h88B5, EtherType that marks a test frame.
REQ-002 Parameter MIN_LEN, 60, minimum number of bytes after SFD (header plus payload) for a frame to be accepted.
REQ-003 Parameter CPCL_W, 4, number of cycles cpcl is held high per accepted frame; legal range is 2..8.
REQ-004 sysclk  in  1  single clock; all logic is on the rising edge.
REQ-005 nrst  in  1  reset, synchronous, active-low.
REQ-006 rx_dv  in  1  receive data valid, one byte per cycle while high.
REQ-007 rx_er  in  1  receive error, sampled while rx_dv is high.
REQ-008 rx_data  in  8  receive byte.
REQ-009 clr_cnt  in  1  single-cycle pulse that clears the statistics counters.
REQ-010 cpcl  out  1  frame-accepted strobe, stretched to CPCL_W cycles, for the downstream edge-detecting checker.
REQ-011 pkt_cnt  out  16  sequence number of the last accepted frame.
REQ-012 good_cnt  out  16  count of accepted frames.
REQ-013 bad_cnt  out  16  count of rejected test frames.

Function
REQ-014 The parser SHALL use the states IDLE, PRE, HDR, DROP.
- IDLE: rx_dv=1 with 8'h55 goes to PRE; rx_dv=1 with any other byte goes to DROP.
- PRE: 8'h55 stays in PRE; 8'hD5 goes to HDR with byte index cleared to 0; any other byte goes to DROP; rx_dv=0 goes to IDLE with no count.
REQ-015 In HDR, each rx_dv=1 cycle SHALL increment an 11-bit byte index, which saturates at 2047.
- Bytes 0..11 (MAC addresses) are ignored.
- Bytes 12,13 are compared big-endian against ETH_TYPE.
- Bytes 14,15 are captured big-endian as the sequence number.
REQ-016 An EtherType mismatch SHALL move the parser to DROP at byte 13, with no counter change.
REQ-017 rx_er=1 on any cycle in PRE or HDR with rx_dv=1 SHALL set an error flag for the current frame.
REQ-018 When rx_dv is sampled 0 in HDR, the parser SHALL return to IDLE and make an accept/reject decision.
- Accept: index >= MIN_LEN and error flag clear. Then pkt_cnt takes the captured sequence number, good_cnt increments (wraps at 16 bits), and the cpcl stretch counter loads CPCL_W.
- Reject: any other case. Then bad_cnt increments (saturates at 16'hFFFF) and pkt_cnt is unchanged.
REQ-019 A frame that ends before byte 16 (no sequence number) SHALL be treated as a reject.
REQ-020 cpcl SHALL rise on the cycle after the cycle in which rx_dv=0 is sampled, and stay high for exactly CPCL_W cycles.
REQ-021 pkt_cnt SHALL change only on the same edge that raises cpcl, and SHALL stay stable until the next accept.
REQ-022 An accept while cpcl is still high SHALL update pkt_cnt and reload the stretch counter, keeping cpcl high. This produces no new rising edge; it is a documented limitation, since a 12-byte inter-frame gap exceeds CPCL_W.
REQ-023 DROP SHALL wait for rx_dv=0, then go to IDLE; no decision is made and no counter changes.
REQ-024 clr_cnt SHALL zero good_cnt and bad_cnt on the next edge; if an increment occurs on the same cycle, clear wins.
REQ-025 A new frame starting on the cycle right after rx_dv falls SHALL be parsed normally.

Reset
REQ-026 When nrst=0 at a rising edge:
- state goes to IDLE;
- cpcl, pkt_cnt, good_cnt and bad_cnt go to 0;
- byte index, error flag and captured sequence number go to 0.
REQ-027 A frame in progress when reset releases SHALL be ignored until rx_dv goes low; the parser goes to DROP if rx_dv=1 with a byte other than 8'h55.

Structure
REQ-028 A shared package SHALL hold the state encoding, the 8'h55/8'hD5 constants and the header byte offsets 12 and 14.
REQ-029 One sub-module, pulse_stretch (counter plus output flag, width set by CPCL_W), is natural for cpcl. Everything else is flat.

Verification
REQ-030 The bench SHALL cover these directed scenarios:
- Good frame: 7x55, D5, 12 bytes, 88 B5, 12 34, 44 pad bytes, 60 bytes total -> cpcl high 4 cycles starting 1 cycle after rx_dv falls; pkt_cnt=16'h1234; good_cnt=1.
- Same frame with rx_er pulsed on byte 30 -> cpcl stays 0; pkt_cnt unchanged; bad_cnt=1.
- Runt frame of 40 bytes -> bad_cnt increments; EtherType 0800 at full length -> no counter change and no cpcl.
- Back-to-back frames with sequence 0xFFFF then 0x0000 and a 12-cycle gap -> two separate cpcl pulses; pkt_cnt wraps 0xFFFF then 0x0000; good_cnt=2.
- clr_cnt on the same cycle as an accept -> good_cnt=0; cpcl still pulses; pkt_cnt updated.
- nrst low for 3 cycles in the middle of a frame -> all outputs 0; the rest of that frame is ignored; the next good frame is accepted.
